issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Registered, parametrised successor to the combinational decode/issue path.
- Accepts decoded instructions from ifetch and resolves rs1/rs2 from regfile, ROB and NUM_CDB broadcast channels.
- Holds up to DEPTH instructions while RS/LSB are full, waking up pending operands from the CDB each cycle.
- Dispatches in order to RS or LSB with valid/ready handshakes; flushes on clr.

Parameters:
- DATA_W, 32, operand/immediate/pc width
- REG_POS_W, 5, architectural register index width
- ROB_POS_W, 5, wrapped ROB position width; value 0 means "no dependency"
- NUM_CDB, 2, number of result broadcast channels (ch0 ALU, ch1 LSB load, extendable)
- DEPTH, 4, queue entries; power of two, >=2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- clr  in  1  misprediction flush
- in_valid  in  1  ifetch presents an instruction
- in_ready  out  1  queue accepts this cycle
- in_openum  in  `OPENUM_TYPE  operation enum
- in_rd  in  REG_POS_W  destination (0 for store/branch)
- in_rs1, in_rs2  in  REG_POS_W  source indices
- in_use_rs1, in_use_rs2  in  1  operand actually read
- in_imm  in  DATA_W  decoded immediate
- in_pc  in  DATA_W  instruction pc
- in_pred_jump  in  1  predictor outcome
- in_to_lsb  in  1  1 = LSB, 0 = RS
- in_ready_inst  in  1  ROB entry ready at issue (stores)
- reg_rs1_pos, reg_rs2_pos  out  REG_POS_W  regfile read index (= in_rs1/in_rs2)
- reg_rs1_val, reg_rs2_val  in  DATA_W  regfile value
- reg_rs1_rob, reg_rs2_rob  in  ROB_POS_W  rename tag
- rob_rs1_pos, rob_rs2_pos  out  ROB_POS_W  ROB query (= reg tags)
- rob_rs1_ready, rob_rs2_ready  in  1  ROB entry complete
- rob_rs1_val, rob_rs2_val  in  DATA_W  ROB value
- rob_next_pos  in  ROB_POS_W  next ROB slot
- rob_alloc  out  1  pulse: ROB slot consumed (= enqueue fire)
- cdb_valid  in  NUM_CDB  channel broadcast valid
- cdb_rob_pos  in  NUM_CDB*ROB_POS_W  flattened tags, ch i at [i*ROB_POS_W +: ROB_POS_W]
- cdb_val  in  NUM_CDB*DATA_W  flattened values
- rs_ready, lsb_ready  in  1  destination has a free slot
- rs_issue, lsb_issue  out  1  dispatch valid to RS / LSB
- out_openum, out_rd, out_imm, out_pc, out_pred_jump, out_ready_inst, out_rob_pos  out  per field  head entry fields
- out_rs1_val, out_rs1_rob, out_rs2_val, out_rs2_rob  out  DATA_W/ROB_POS_W  head operands after bypass

Behaviour:
- Reset/clr (synchronous): count=0, head=tail=0, all entry valid bits 0. Outputs: rs_issue=lsb_issue=rob_alloc=0, data outputs 0. While clr is high: in_ready=0, no enqueue, no dispatch.
- rdy low: in_ready=0, rs_issue=lsb_issue=0, no state change.
- Enqueue fire = in_valid & in_ready, with in_ready = rdy & !clr & !rst & (count<DEPTH). No full-queue pass-through.
- On enqueue: rob_alloc=1 that cycle; entry rob_pos=rob_next_pos.
- Operand resolution at enqueue, per operand, in priority order:
  - !use -> val 0, tag 0
  - reg tag==0 -> regfile val
  - rob ready -> ROB val
  - lowest-index matching CDB channel (valid & tag equal) -> CDB val
  - else val 0, tag = reg tag
- Wake-up: every cycle, each valid entry operand with tag!=0 that matches a CDB channel captures val, tag:=0. Lowest index wins on duplicates. Wake-up applies to the entry being dequeued in that cycle.
- Dispatch: head valid & !clr & rdy.
  - to_lsb=0 -> rs_issue=1; fire when rs_ready.
  - to_lsb=1 -> lsb_issue=1; fire when lsb_ready.
  - Issue is not gated by the opposite ready.
  - Latency: enqueue at edge N makes the entry dispatchable in cycle N+1.
- Output bypass: out_rsX_val/out_rsX_rob are combinationally merged with the current cycle's CDB match, so a dispatched operand never misses a broadcast.
- Simultaneous enqueue + dequeue: count unchanged, both pointers advance modulo DEPTH.
- Head stays stable (fields and dispatch valid) until fire; only operand tags/vals may resolve.
- Tag 0 on a CDB channel is ignored.

Decomposition:
- definition.v: OPENUM_TYPE, ROB_WRAP_POS_TYPE, REG_POS_TYPE, DATA_TYPE, TRUE/FALSE, opcode enums.
- Sub-module cdb_match, parametrised by NUM_CDB: combinational tag compare returning hit and value. Instantiated for 2 enqueue operands, 2·DEPTH wake-ups, and 2 output bypasses.

Test Plan:
- Reset then in_valid=1, use_rs1, reg tag 0, val 0x11 -> rob_alloc=1; next cycle rs_issue=1, out_rs1_val=0x11, out_rs1_rob=0.
- Enqueue rs1 tag 3, ROB not ready; two cycles later cdb_valid[1]=1, tag 3, val 0xABCD -> entry out_rs1_rob=0, val 0xABCD; dispatch after rs_ready.
- Enqueue while ch0 and ch1 both broadcast tag 5 with 0x1/0x2 -> captured value 0x1.
- rs_ready=0, enqueue DEPTH=4 instructions -> in_ready=0 on the 5th. Raise rs_ready -> dispatched in order 1..4, pointers wrap.
- Queue holds 3 entries, clr=1 for one cycle -> rs_issue=lsb_issue=0 next cycle, count=0, in_ready=1.
- Head to_lsb=1, lsb_ready=0, rs_ready=1 -> lsb_issue=1, rs_issue=0, queue stalls. rdy=0 mid-stall -> all outputs valid=0, state held.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared types and default sizing for the decode/issue queue.
package issue_queue_pkg;

    localparam int OPENUM_W      = 6;
    localparam int DATA_W_DEF    = 32;
    localparam int REG_POS_W_DEF = 5;
    localparam int ROB_POS_W_DEF = 5;
    localparam int NUM_CDB_DEF   = 2;
    localparam int DEPTH_DEF     = 4;

    typedef logic [OPENUM_W-1:0] openum_t;

    typedef enum logic [OPENUM_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_LW    = 6'd6,
        OP_SW    = 6'd7,
        OP_ADDI  = 6'd8,
        OP_ADD   = 6'd9
    } opcode_e;

endpackage

// File: rtl/issue_queue_if.sv
// Issue-queue bus: ifetch input, regfile/ROB lookups, CDB broadcast and RS/LSB dispatch.
interface issue_queue_if #(
    parameter int DATA_W    = issue_queue_pkg::DATA_W_DEF,
    parameter int REG_POS_W = issue_queue_pkg::REG_POS_W_DEF,
    parameter int ROB_POS_W = issue_queue_pkg::ROB_POS_W_DEF,
    parameter int NUM_CDB   = issue_queue_pkg::NUM_CDB_DEF
);
    import issue_queue_pkg::*;

    logic                         in_valid, in_ready;
    openum_t                      in_openum;
    logic [REG_POS_W-1:0]         in_rd, in_rs1, in_rs2;
    logic                         in_use_rs1, in_use_rs2;
    logic [DATA_W-1:0]            in_imm, in_pc;
    logic                         in_pred_jump, in_to_lsb, in_ready_inst;

    logic [REG_POS_W-1:0]         reg_rs1_pos, reg_rs2_pos;
    logic [DATA_W-1:0]            reg_rs1_val, reg_rs2_val;
    logic [ROB_POS_W-1:0]         reg_rs1_rob, reg_rs2_rob;

    logic [ROB_POS_W-1:0]         rob_rs1_pos, rob_rs2_pos;
    logic                         rob_rs1_ready, rob_rs2_ready;
    logic [DATA_W-1:0]            rob_rs1_val, rob_rs2_val;
    logic [ROB_POS_W-1:0]         rob_next_pos;
    logic                         rob_alloc;

    logic [NUM_CDB-1:0]           cdb_valid;
    logic [NUM_CDB*ROB_POS_W-1:0] cdb_rob_pos;
    logic [NUM_CDB*DATA_W-1:0]    cdb_val;

    logic                         rs_ready, lsb_ready, rs_issue, lsb_issue;
    openum_t                      out_openum;
    logic [REG_POS_W-1:0]         out_rd;
    logic [DATA_W-1:0]            out_imm, out_pc;
    logic                         out_pred_jump, out_ready_inst;
    logic [ROB_POS_W-1:0]         out_rob_pos;
    logic [DATA_W-1:0]            out_rs1_val, out_rs2_val;
    logic [ROB_POS_W-1:0]         out_rs1_rob, out_rs2_rob;

    modport slave (
        input  in_valid, in_openum, in_rd, in_rs1, in_rs2, in_use_rs1, in_use_rs2,
               in_imm, in_pc, in_pred_jump, in_to_lsb, in_ready_inst,
               reg_rs1_val, reg_rs2_val, reg_rs1_rob, reg_rs2_rob,
               rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val, rob_next_pos,
               cdb_valid, cdb_rob_pos, cdb_val, rs_ready, lsb_ready,
        output in_ready, reg_rs1_pos, reg_rs2_pos, rob_rs1_pos, rob_rs2_pos, rob_alloc,
               rs_issue, lsb_issue, out_openum, out_rd, out_imm, out_pc, out_pred_jump,
               out_ready_inst, out_rob_pos, out_rs1_val, out_rs1_rob, out_rs2_val, out_rs2_rob
    );

    modport master (
        output in_valid, in_openum, in_rd, in_rs1, in_rs2, in_use_rs1, in_use_rs2,
               in_imm, in_pc, in_pred_jump, in_to_lsb, in_ready_inst,
               reg_rs1_val, reg_rs2_val, reg_rs1_rob, reg_rs2_rob,
               rob_rs1_ready, rob_rs2_ready, rob_rs1_val, rob_rs2_val, rob_next_pos,
               cdb_valid, cdb_rob_pos, cdb_val, rs_ready, lsb_ready,
        input  in_ready, reg_rs1_pos, reg_rs2_pos, rob_rs1_pos, rob_rs2_pos, rob_alloc,
               rs_issue, lsb_issue, out_openum, out_rd, out_imm, out_pc, out_pred_jump,
               out_ready_inst, out_rob_pos, out_rs1_val, out_rs1_rob, out_rs2_val, out_rs2_rob
    );

endinterface

// File: rtl/issue_queue_cdb_match.sv
// Compares one rename tag against all CDB channels; lowest channel index wins, tag 0 never hits.
module issue_queue_cdb_match #(
    parameter int DATA_W    = 32,
    parameter int ROB_POS_W = 5,
    parameter int NUM_CDB   = 2
) (
    input  logic [ROB_POS_W-1:0]         tag_i,
    input  logic [NUM_CDB-1:0]           cdb_valid_i,
    input  logic [NUM_CDB*ROB_POS_W-1:0] cdb_rob_pos_i,
    input  logic [NUM_CDB*DATA_W-1:0]    cdb_val_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            val_o
);

    // Scan downwards so the lowest matching channel is written last.
    always_comb begin
        hit_o = 1'b0;
        val_o = '0;
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (cdb_valid_i[i] && (tag_i != '0) &&
                (cdb_rob_pos_i[i*ROB_POS_W +: ROB_POS_W] == tag_i)) begin
                hit_o = 1'b1;
                val_o = cdb_val_i[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: resolves operands at enqueue, wakes pending ones from the CDB,
// and dispatches the head to RS or LSB with a bypass on the current broadcast.
module issue_queue #(
    parameter int DATA_W    = issue_queue_pkg::DATA_W_DEF,
    parameter int REG_POS_W = issue_queue_pkg::REG_POS_W_DEF,
    parameter int ROB_POS_W = issue_queue_pkg::ROB_POS_W_DEF,
    parameter int NUM_CDB   = issue_queue_pkg::NUM_CDB_DEF,
    parameter int DEPTH     = issue_queue_pkg::DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         clr,
    issue_queue_if.slave bus
);
    import issue_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic                 valid;
        openum_t              openum;
        logic [REG_POS_W-1:0] rd;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    pc;
        logic                 pred_jump;
        logic                 to_lsb;
        logic                 ready_inst;
        logic [ROB_POS_W-1:0] rob_pos;
        logic [DATA_W-1:0]    rs1_val;
        logic [ROB_POS_W-1:0] rs1_rob;
        logic [DATA_W-1:0]    rs2_val;
        logic [ROB_POS_W-1:0] rs2_rob;
    } entry_t;

    entry_t               entry_q [DEPTH];
    entry_t               entry_d [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    entry_t               head, head_out, new_entry;
    logic                 in_ready_w, enq_fire, issue_ok, rs_issue_w, lsb_issue_w, deq_fire;
    logic                 enq1_hit, enq2_hit, byp1_hit, byp2_hit;
    logic [DATA_W-1:0]    enq1_val, enq2_val, byp1_val, byp2_val;
    logic [DEPTH-1:0]     wake1_hit, wake2_hit;
    logic [DATA_W-1:0]    wake1_val [DEPTH];
    logic [DATA_W-1:0]    wake2_val [DEPTH];

    // Operand value/tag at enqueue: unused, regfile, ROB, CDB, else still pending.
    function automatic logic [DATA_W+ROB_POS_W-1:0] resolve(
        input logic use_op, input logic [DATA_W-1:0] reg_val, input logic [ROB_POS_W-1:0] reg_rob,
        input logic rob_ready, input logic [DATA_W-1:0] rob_val,
        input logic cdb_hit, input logic [DATA_W-1:0] cdb_val);
        if (!use_op)           return '0;
        if (reg_rob == '0)     return {reg_val, {ROB_POS_W{1'b0}}};
        if (rob_ready)         return {rob_val, {ROB_POS_W{1'b0}}};
        if (cdb_hit)           return {cdb_val, {ROB_POS_W{1'b0}}};
        return {{DATA_W{1'b0}}, reg_rob};
    endfunction

    issue_queue_cdb_match #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W), .NUM_CDB(NUM_CDB)) u_enq1 (
        .tag_i(bus.reg_rs1_rob), .cdb_valid_i(bus.cdb_valid), .cdb_rob_pos_i(bus.cdb_rob_pos),
        .cdb_val_i(bus.cdb_val), .hit_o(enq1_hit), .val_o(enq1_val));
    issue_queue_cdb_match #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W), .NUM_CDB(NUM_CDB)) u_enq2 (
        .tag_i(bus.reg_rs2_rob), .cdb_valid_i(bus.cdb_valid), .cdb_rob_pos_i(bus.cdb_rob_pos),
        .cdb_val_i(bus.cdb_val), .hit_o(enq2_hit), .val_o(enq2_val));
    issue_queue_cdb_match #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W), .NUM_CDB(NUM_CDB)) u_byp1 (
        .tag_i(head_out.rs1_rob), .cdb_valid_i(bus.cdb_valid), .cdb_rob_pos_i(bus.cdb_rob_pos),
        .cdb_val_i(bus.cdb_val), .hit_o(byp1_hit), .val_o(byp1_val));
    issue_queue_cdb_match #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W), .NUM_CDB(NUM_CDB)) u_byp2 (
        .tag_i(head_out.rs2_rob), .cdb_valid_i(bus.cdb_valid), .cdb_rob_pos_i(bus.cdb_rob_pos),
        .cdb_val_i(bus.cdb_val), .hit_o(byp2_hit), .val_o(byp2_val));

    for (genvar i = 0; i < DEPTH; i++) begin : g_wake
        issue_queue_cdb_match #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W), .NUM_CDB(NUM_CDB)) u_rs1 (
            .tag_i(entry_q[i].rs1_rob), .cdb_valid_i(bus.cdb_valid), .cdb_rob_pos_i(bus.cdb_rob_pos),
            .cdb_val_i(bus.cdb_val), .hit_o(wake1_hit[i]), .val_o(wake1_val[i]));
        issue_queue_cdb_match #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W), .NUM_CDB(NUM_CDB)) u_rs2 (
            .tag_i(entry_q[i].rs2_rob), .cdb_valid_i(bus.cdb_valid), .cdb_rob_pos_i(bus.cdb_rob_pos),
            .cdb_val_i(bus.cdb_val), .hit_o(wake2_hit[i]), .val_o(wake2_val[i]));
    end

    assign in_ready_w  = rdy & ~clr & ~rst & (count_q < DEPTH_C);
    assign enq_fire    = bus.in_valid & in_ready_w;
    assign head        = entry_q[head_q];
    assign head_out    = head.valid ? head : '0;
    assign issue_ok    = head_out.valid & rdy & ~clr & ~rst;
    assign rs_issue_w  = issue_ok & ~head_out.to_lsb;
    assign lsb_issue_w = issue_ok & head_out.to_lsb;
    assign deq_fire    = (rs_issue_w & bus.rs_ready) | (lsb_issue_w & bus.lsb_ready);

    assign bus.in_ready       = in_ready_w;
    assign bus.rob_alloc      = enq_fire;
    assign bus.reg_rs1_pos    = bus.in_rs1;
    assign bus.reg_rs2_pos    = bus.in_rs2;
    assign bus.rob_rs1_pos    = bus.reg_rs1_rob;
    assign bus.rob_rs2_pos    = bus.reg_rs2_rob;
    assign bus.rs_issue       = rs_issue_w;
    assign bus.lsb_issue      = lsb_issue_w;
    assign bus.out_openum     = head_out.openum;
    assign bus.out_rd         = head_out.rd;
    assign bus.out_imm        = head_out.imm;
    assign bus.out_pc         = head_out.pc;
    assign bus.out_pred_jump  = head_out.pred_jump;
    assign bus.out_ready_inst = head_out.ready_inst;
    assign bus.out_rob_pos    = head_out.rob_pos;
    assign bus.out_rs1_val    = byp1_hit ? byp1_val : head_out.rs1_val;
    assign bus.out_rs1_rob    = byp1_hit ? '0 : head_out.rs1_rob;
    assign bus.out_rs2_val    = byp2_hit ? byp2_val : head_out.rs2_val;
    assign bus.out_rs2_rob    = byp2_hit ? '0 : head_out.rs2_rob;

    always_comb begin
        new_entry            = '0;
        new_entry.valid      = 1'b1;
        new_entry.openum     = bus.in_openum;
        new_entry.rd         = bus.in_rd;
        new_entry.imm        = bus.in_imm;
        new_entry.pc         = bus.in_pc;
        new_entry.pred_jump  = bus.in_pred_jump;
        new_entry.to_lsb     = bus.in_to_lsb;
        new_entry.ready_inst = bus.in_ready_inst;
        new_entry.rob_pos    = bus.rob_next_pos;
        {new_entry.rs1_val, new_entry.rs1_rob} = resolve(bus.in_use_rs1, bus.reg_rs1_val,
            bus.reg_rs1_rob, bus.rob_rs1_ready, bus.rob_rs1_val, enq1_hit, enq1_val);
        {new_entry.rs2_val, new_entry.rs2_rob} = resolve(bus.in_use_rs2, bus.reg_rs2_val,
            bus.reg_rs2_rob, bus.rob_rs2_ready, bus.rob_rs2_val, enq2_hit, enq2_val);
    end

    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_q[i].valid && wake1_hit[i]) begin
                    entry_d[i].rs1_val = wake1_val[i];
                    entry_d[i].rs1_rob = '0;
                end
                if (entry_q[i].valid && wake2_hit[i]) begin
                    entry_d[i].rs2_val = wake2_val[i];
                    entry_d[i].rs2_rob = '0;
                end
            end
            // Full blocks enqueue and empty blocks dequeue, so both never hit one slot.
            if (deq_fire) begin
                entry_d[head_q].valid = 1'b0;
                head_d = head_q + 1'b1;
            end
            if (enq_fire) begin
                entry_d[tail_q] = new_entry;
                tail_d = tail_q + 1'b1;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed and randomized checks of issue_queue against a queue-based reference model.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DW = 32, RW = 5, TW = 5, NC = 2, DEPTH = 4;

    logic clk = 1'b0;
    logic rst, rdy, clr;
    always #5 clk = ~clk;

    issue_queue_if #(.DATA_W(DW), .REG_POS_W(RW), .ROB_POS_W(TW), .NUM_CDB(NC)) iq_if ();

    issue_queue #(.DATA_W(DW), .REG_POS_W(RW), .ROB_POS_W(TW), .NUM_CDB(NC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .bus(iq_if.slave));

    typedef struct {
        logic [5:0]    op;
        logic [RW-1:0] rd;
        logic [DW-1:0] imm, pc;
        logic          pj, lsb, ri;
        logic [TW-1:0] rob;
        logic [DW-1:0] v1, v2;
        logic [TW-1:0] t1, t2;
    } ment_t;

    ment_t         mq[$];
    int            checks = 0, failures = 0;
    logic          cv [NC];
    logic [TW-1:0] ct [NC];
    logic [DW-1:0] cd [NC];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void cdb_lookup(input logic [TW-1:0] tag, output logic hit, output logic [DW-1:0] val);
        hit = 1'b0;
        val = '0;
        if (tag == '0) return;
        for (int ch = 0; ch < NC; ch++)
            if (!hit && cv[ch] && ct[ch] == tag) begin
                hit = 1'b1;
                val = cd[ch];
            end
    endfunction

    function automatic void resolve(input logic use_op, input logic [DW-1:0] rv, input logic [TW-1:0] rt,
                                    input logic rr, input logic [DW-1:0] robv,
                                    output logic [DW-1:0] v, output logic [TW-1:0] t);
        logic          h;
        logic [DW-1:0] hv;
        v = '0;
        t = '0;
        if (!use_op) return;
        if (rt == '0) v = rv;
        else if (rr) v = robv;
        else begin
            cdb_lookup(rt, h, hv);
            if (h) v = hv;
            else   t = rt;
        end
    endfunction

    task automatic idle();
        rdy = 1'b1; clr = 1'b0;
        iq_if.in_valid = 1'b0; iq_if.in_openum = '0; iq_if.in_rd = '0;
        iq_if.in_rs1 = '0; iq_if.in_rs2 = '0; iq_if.in_use_rs1 = 1'b0; iq_if.in_use_rs2 = 1'b0;
        iq_if.in_imm = '0; iq_if.in_pc = '0; iq_if.in_pred_jump = 1'b0;
        iq_if.in_to_lsb = 1'b0; iq_if.in_ready_inst = 1'b0;
        iq_if.reg_rs1_val = '0; iq_if.reg_rs2_val = '0; iq_if.reg_rs1_rob = '0; iq_if.reg_rs2_rob = '0;
        iq_if.rob_rs1_ready = 1'b0; iq_if.rob_rs2_ready = 1'b0;
        iq_if.rob_rs1_val = '0; iq_if.rob_rs2_val = '0; iq_if.rob_next_pos = '0;
        iq_if.rs_ready = 1'b0; iq_if.lsb_ready = 1'b0;
        for (int ch = 0; ch < NC; ch++) begin cv[ch] = 1'b0; ct[ch] = '0; cd[ch] = '0; end
    endtask

    task automatic inst(input logic lsb, input logic [TW-1:0] tag1, input logic [DW-1:0] val1);
        iq_if.in_valid = 1'b1; iq_if.in_to_lsb = lsb;
        iq_if.in_use_rs1 = 1'b1; iq_if.reg_rs1_rob = tag1; iq_if.reg_rs1_val = val1;
        iq_if.in_openum = 6'($urandom); iq_if.in_rd = RW'($urandom);
        iq_if.in_imm = $urandom; iq_if.in_pc = $urandom;
        iq_if.rob_next_pos = TW'($urandom_range(1, 31));
    endtask

    task automatic rand_inputs(input int rp);
        rdy = ($urandom_range(0, 9) != 0);
        clr = rdy && ($urandom_range(0, 39) == 0);
        iq_if.in_valid = ($urandom_range(0, 2) != 0);
        iq_if.in_openum = 6'($urandom); iq_if.in_rd = RW'($urandom);
        iq_if.in_rs1 = RW'($urandom); iq_if.in_rs2 = RW'($urandom);
        iq_if.in_use_rs1 = ($urandom_range(0, 4) != 0); iq_if.in_use_rs2 = ($urandom_range(0, 1) != 0);
        iq_if.in_imm = $urandom; iq_if.in_pc = $urandom;
        iq_if.in_pred_jump = ($urandom_range(0, 1) != 0); iq_if.in_to_lsb = ($urandom_range(0, 2) == 0);
        iq_if.in_ready_inst = ($urandom_range(0, 1) != 0);
        iq_if.reg_rs1_val = $urandom; iq_if.reg_rs2_val = $urandom;
        iq_if.reg_rs1_rob = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 7));
        iq_if.reg_rs2_rob = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 7));
        iq_if.rob_rs1_ready = ($urandom_range(0, 3) == 0); iq_if.rob_rs2_ready = ($urandom_range(0, 3) == 0);
        iq_if.rob_rs1_val = $urandom; iq_if.rob_rs2_val = $urandom;
        iq_if.rob_next_pos = TW'($urandom);
        iq_if.rs_ready = ($urandom_range(0, 99) < rp); iq_if.lsb_ready = ($urandom_range(0, 99) < rp);
        for (int ch = 0; ch < NC; ch++) begin
            cv[ch] = ($urandom_range(0, 1) != 0);
            ct[ch] = TW'($urandom_range(0, 7));
            cd[ch] = $urandom;
        end
    endtask

    // Applies the prepared inputs for one cycle, checks outputs, then advances the model.
    task automatic step();
        logic          h, e_ready, e_rs, e_lsb, enq, deq;
        logic [DW-1:0] hv;
        ment_t         e, n;
        for (int ch = 0; ch < NC; ch++) begin
            iq_if.cdb_valid[ch] = cv[ch];
            iq_if.cdb_rob_pos[ch*TW +: TW] = ct[ch];
            iq_if.cdb_val[ch*DW +: DW] = cd[ch];
        end
        @(negedge clk);
        e_ready = rdy && !clr && !rst && (mq.size() < DEPTH);
        enq = iq_if.in_valid && e_ready;
        e_rs = 1'b0;
        e_lsb = 1'b0;
        if (mq.size() > 0 && rdy && !clr && !rst) begin
            e_rs = !mq[0].lsb;
            e_lsb = mq[0].lsb;
        end
        chk("in_ready", 64'(iq_if.in_ready), 64'(e_ready));
        chk("rob_alloc", 64'(iq_if.rob_alloc), 64'(enq));
        chk("rs_issue", 64'(iq_if.rs_issue), 64'(e_rs));
        chk("lsb_issue", 64'(iq_if.lsb_issue), 64'(e_lsb));
        chk("reg_rs1_pos", 64'(iq_if.reg_rs1_pos), 64'(iq_if.in_rs1));
        chk("rob_rs2_pos", 64'(iq_if.rob_rs2_pos), 64'(iq_if.reg_rs2_rob));
        if (e_rs || e_lsb) begin
            e = mq[0];
            chk("out_openum", 64'(iq_if.out_openum), 64'(e.op));
            chk("out_rd", 64'(iq_if.out_rd), 64'(e.rd));
            chk("out_imm", 64'(iq_if.out_imm), 64'(e.imm));
            chk("out_pc", 64'(iq_if.out_pc), 64'(e.pc));
            chk("out_pred_jump", 64'(iq_if.out_pred_jump), 64'(e.pj));
            chk("out_ready_inst", 64'(iq_if.out_ready_inst), 64'(e.ri));
            chk("out_rob_pos", 64'(iq_if.out_rob_pos), 64'(e.rob));
            cdb_lookup(e.t1, h, hv);
            chk("out_rs1_val", 64'(iq_if.out_rs1_val), 64'(h ? hv : e.v1));
            chk("out_rs1_rob", 64'(iq_if.out_rs1_rob), 64'(h ? '0 : e.t1));
            cdb_lookup(e.t2, h, hv);
            chk("out_rs2_val", 64'(iq_if.out_rs2_val), 64'(h ? hv : e.v2));
            chk("out_rs2_rob", 64'(iq_if.out_rs2_rob), 64'(h ? '0 : e.t2));
        end
        if (rst || clr) mq.delete();
        else if (rdy) begin
            deq = (e_rs && iq_if.rs_ready) || (e_lsb && iq_if.lsb_ready);
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                cdb_lookup(e.t1, h, hv);
                if (h) begin e.v1 = hv; e.t1 = '0; end
                cdb_lookup(e.t2, h, hv);
                if (h) begin e.v2 = hv; e.t2 = '0; end
                mq[i] = e;
            end
            if (deq) void'(mq.pop_front());
            if (enq) begin
                n.op = iq_if.in_openum; n.rd = iq_if.in_rd; n.imm = iq_if.in_imm; n.pc = iq_if.in_pc;
                n.pj = iq_if.in_pred_jump; n.lsb = iq_if.in_to_lsb; n.ri = iq_if.in_ready_inst;
                n.rob = iq_if.rob_next_pos;
                resolve(iq_if.in_use_rs1, iq_if.reg_rs1_val, iq_if.reg_rs1_rob, iq_if.rob_rs1_ready,
                        iq_if.rob_rs1_val, n.v1, n.t1);
                resolve(iq_if.in_use_rs2, iq_if.reg_rs2_val, iq_if.reg_rs2_rob, iq_if.rob_rs2_ready,
                        iq_if.rob_rs2_val, n.v2, n.t2);
                mq.push_back(n);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_pc", 64'(iq_if.out_pc), 64'd0);
        chk("rst_out_rs1_val", 64'(iq_if.out_rs1_val), 64'd0);
        chk("rst_out_rob_pos", 64'(iq_if.out_rob_pos), 64'd0);
        chk("rst_rs_issue", 64'(iq_if.rs_issue), 64'd0);
        chk("rst_in_ready", 64'(iq_if.in_ready), 64'd1);
        @(posedge clk); #1;

        // basic: regfile operand, dispatch the following cycle
        inst(1'b0, '0, 32'h11); step();
        idle(); iq_if.rs_ready = 1'b1; step(); step();

        // pending operand woken by CDB channel 1
        inst(1'b0, 5'd3, 32'h0); step();
        idle(); step(); step();
        cv[1] = 1'b1; ct[1] = 5'd3; cd[1] = 32'hABCD; step();
        idle(); step();
        iq_if.rs_ready = 1'b1; step(); step();

        // both channels broadcast the same tag at enqueue
        inst(1'b0, 5'd5, 32'h0);
        cv[0] = 1'b1; ct[0] = 5'd5; cd[0] = 32'h1;
        cv[1] = 1'b1; ct[1] = 5'd5; cd[1] = 32'h2;
        step();
        idle(); iq_if.rs_ready = 1'b1; step(); step();

        // fill to DEPTH, fifth is refused, then drain in order with pointer wrap
        for (int k = 0; k < 5; k++) begin idle(); inst(1'b0, '0, 32'(k + 1)); step(); end
        idle(); iq_if.rs_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();

        // flush with three entries held
        for (int k = 0; k < 3; k++) begin idle(); inst(1'b0, '0, 32'(k)); step(); end
        idle(); clr = 1'b1; step();
        idle(); step();

        // LSB head stalls regardless of rs_ready; rdy low freezes everything
        inst(1'b1, '0, 32'h77); step();
        idle(); iq_if.rs_ready = 1'b1; step(); step();
        rdy = 1'b0; iq_if.in_valid = 1'b1; step(); step();
        idle(); iq_if.lsb_ready = 1'b1; step(); step();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rand_inputs(((cyc / 150) % 2 == 0) ? 20 : 85);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
